// File: rtl/mdu_stall_ctrl_pkg.sv
// Shared constants for the MDU stall controller: MDUOp encodings and FSM state codes.
// Contents: MDU_OP_W, MDU_* opcode constants, mdu_state_e.
// No logic; imported by the interface, the decoder and the top.
package mdu_stall_ctrl_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NOP   = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_stall_ctrl_if.sv
// Pipeline-side bundle of the MDU stall controller.
// Inputs: E-stage op/valid/flush, D-stage op/valid. Outputs: stall_d, busy, remain, done, overlap_err.
// master = pipeline driving stage info, slave = the controller.
interface mdu_stall_ctrl_if
  import mdu_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) ();
  logic                e_valid;
  logic [MDU_OP_W-1:0] e_mdu_op;
  logic                e_flush;
  logic                d_valid;
  logic [MDU_OP_W-1:0] d_mdu_op;
  logic                stall_d;
  logic                busy;
  logic [CNT_W-1:0]    remain;
  logic                done;
  logic                overlap_err;

  modport master (
    output e_valid, e_mdu_op, e_flush, d_valid, d_mdu_op,
    input  stall_d, busy, remain, done, overlap_err
  );

  modport slave (
    input  e_valid, e_mdu_op, e_flush, d_valid, d_mdu_op,
    output stall_d, busy, remain, done, overlap_err
  );
endinterface

// File: rtl/mdu_stall_ctrl_op_class.sv
// Combinational MDUOp classifier, used once for E and once for D.
// Ports: op in; is_start (op kicks off a multiply/divide), is_div, uses_hilo out.
// Undefined encodings classify as non-MDU.
module mdu_op_class
  import mdu_stall_ctrl_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  output logic                is_start,
  output logic                is_div,
  output logic                uses_hilo
);
  always_comb begin
    is_start  = 1'b0;
    is_div    = 1'b0;
    uses_hilo = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_MADDU: begin
        is_start  = 1'b1;
        uses_hilo = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        is_start  = 1'b1;
        is_div    = 1'b1;
        uses_hilo = 1'b1;
      end
      MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO: uses_hilo = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/mdu_stall_ctrl.sv
// Decode-stage stall controller for the multiply/divide unit: counts busy cycles from E-stage issue.
// Ports: clk, rst (sync, active-high), bus (slave modport) carrying E/D stage info and status outputs.
// stall_d is combinational; busy/remain/done/overlap_err are registered.
module mdu_stall_ctrl
  import mdu_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  mdu_stall_ctrl_if.slave   bus
);
  logic e_is_start, e_is_div, e_uses_hilo;
  logic d_is_start, d_is_div, d_uses_hilo;
  logic unused_class_bits;

  mdu_op_class u_e_class (
    .op        (bus.e_mdu_op),
    .is_start  (e_is_start),
    .is_div    (e_is_div),
    .uses_hilo (e_uses_hilo)
  );

  mdu_op_class u_d_class (
    .op        (bus.d_mdu_op),
    .is_start  (d_is_start),
    .is_div    (d_is_div),
    .uses_hilo (d_uses_hilo)
  );

  assign unused_class_bits = e_uses_hilo | d_is_start | d_is_div;

  logic             start;
  logic             d_uses;
  logic [CNT_W-1:0] load;

  // A flushed E instruction never starts; it cannot cancel a count already running.
  assign start  = bus.e_valid & ~bus.e_flush & e_is_start;
  assign d_uses = bus.d_valid & d_uses_hilo;
  assign load   = e_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  mdu_state_e       state;
  logic [CNT_W-1:0] remain_q;
  logic             busy_q;
  logic             done_q;
  logic             overlap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remain_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            remain_q <= load;
            busy_q   <= 1'b1;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A start here means the stall was ignored upstream: restart the count and flag it.
          if (start) begin
            remain_q  <= load;
            overlap_q <= 1'b1;
          end else if (remain_q == CNT_W'(1)) begin
            remain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            remain_q <= remain_q - CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          remain_q <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // The start term covers the issue cycle, before busy has risen.
  assign bus.stall_d     = d_uses & (start | busy_q);
  assign bus.busy        = busy_q;
  assign bus.remain      = remain_q;
  assign bus.done        = done_q;
  assign bus.overlap_err = overlap_q;
endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// Self-checking bench for mdu_stall_ctrl: per-scenario tasks push expected per-cycle outputs to a
// scoreboard queue as stimulus is driven, then pop and compare at the negative edge.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_mdu_stall_ctrl;
  import mdu_stall_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  mdu_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mdu_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             busy;
    logic [CNT_W-1:0] remain;
    logic             done;
    logic             stall;
    logic             oerr;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic oerr_exp = 1'b0;

  function automatic obs_t mk(logic b, int r, logic d, logic s, logic o);
    obs_t x;
    x.busy   = b;
    x.remain = CNT_W'(r);
    x.done   = d;
    x.stall  = s;
    x.oerr   = o;
    return x;
  endfunction

  function automatic obs_t sample();
    obs_t x;
    x.busy   = bus.busy;
    x.remain = bus.remain;
    x.done   = bus.done;
    x.stall  = bus.stall_d;
    x.oerr   = bus.overlap_err;
    return x;
  endfunction

  function automatic string fmt(obs_t x);
    return $sformatf("busy=%0b remain=%0d done=%0b stall_d=%0b overlap_err=%0b",
                     x.busy, x.remain, x.done, x.stall, x.oerr);
  endfunction

  task automatic drive(logic ev, logic [3:0] eop, logic ef, logic dv, logic [3:0] dop);
    bus.e_valid  = ev;
    bus.e_mdu_op = eop;
    bus.e_flush  = ef;
    bus.d_valid  = dv;
    bus.d_mdu_op = dop;
  endtask

  // Reset overrides a start presented in the same cycle.
  task automatic test_reset();
    obs_t e, o;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      rst = (c < 2);
      drive(c < 2, MDU_MULT, 1'b0, 1'b1, MDU_NOP);
      sb.push_back(mk(0, 0, 0, 0, 0));
      @(negedge clk);
      o = sample(); e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  // MULT at c0 with MFLO in D: stall c0..5, busy c1..5, done c6.
  task automatic test_mult();
    obs_t e, o;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      drive(c == 0, MDU_MULT, 1'b0, 1'b1, MDU_MFLO);
      if (c == 0)      sb.push_back(mk(0, 0, 0, 1, oerr_exp));
      else if (c <= 5) sb.push_back(mk(1, 6 - c, 0, 1, oerr_exp));
      else if (c == 6) sb.push_back(mk(0, 0, 1, 0, oerr_exp));
      else             sb.push_back(mk(0, 0, 0, 0, oerr_exp));
      @(negedge clk);
      o = sample(); e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mult c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  // DIVU with non-MDU / undefined / invalid D ops, then a live MTHI stalls until busy falls.
  task automatic test_divu_nonmdu();
    obs_t e, o;
    logic [3:0] dop;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      dop = (c == 0) ? MDU_NOP : (c <= 2) ? 4'hE : MDU_MTHI;
      drive(c == 0, MDU_DIVU, 1'b0, !(c >= 3 && c <= 5), dop);
      if (c == 0)       sb.push_back(mk(0, 0, 0, 0, oerr_exp));
      else if (c <= 5)  sb.push_back(mk(1, 11 - c, 0, 0, oerr_exp));
      else if (c <= 10) sb.push_back(mk(1, 11 - c, 0, 1, oerr_exp));
      else              sb.push_back(mk(0, 0, 1, 0, oerr_exp));
      @(negedge clk);
      o = sample(); e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL divu c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  // Flushed DIV (c0) and an op with e_valid=0 (c2) never start anything.
  task automatic test_flush();
    obs_t e, o;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive(c == 0, MDU_DIV, c == 0, 1'b1, MDU_MFHI);
      sb.push_back(mk(0, 0, 0, 0, oerr_exp));
      @(negedge clk);
      o = sample(); e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL flush c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  // MULT completes; DIV starts in the done cycle and is accepted.
  task automatic test_back_to_back();
    obs_t e, o;
    for (int c = 0; c < 19; c++) begin
      @(posedge clk); #1;
      if (c == 0)      drive(1'b1, MDU_MULT, 1'b0, 1'b1, MDU_NOP);
      else if (c < 6)  drive(1'b0, MDU_NOP, 1'b0, 1'b1, MDU_NOP);
      else if (c == 6) drive(1'b1, MDU_DIV, 1'b0, 1'b1, MDU_MFLO);
      else             drive(1'b0, MDU_NOP, 1'b0, 1'b1, MDU_MFLO);
      if (c == 0)       sb.push_back(mk(0, 0, 0, 0, oerr_exp));
      else if (c <= 5)  sb.push_back(mk(1, 6 - c, 0, 0, oerr_exp));
      else if (c == 6)  sb.push_back(mk(0, 0, 1, 1, oerr_exp));
      else if (c <= 16) sb.push_back(mk(1, 17 - c, 0, 1, oerr_exp));
      else if (c == 17) sb.push_back(mk(0, 0, 1, 0, oerr_exp));
      else              sb.push_back(mk(0, 0, 0, 0, oerr_exp));
      @(negedge clk);
      o = sample(); e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  // MULTU forced while remain=2: reload to 5, overlap_err sticks.
  task automatic test_overlap();
    obs_t e, o;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 0)      drive(1'b1, MDU_MULT, 1'b0, 1'b1, MDU_NOP);
      else if (c == 4) drive(1'b1, MDU_MULTU, 1'b0, 1'b1, MDU_NOP);
      else             drive(1'b0, MDU_NOP, 1'b0, 1'b1, MDU_NOP);
      if (c >= 5) oerr_exp = 1'b1;
      if (c == 0)       sb.push_back(mk(0, 0, 0, 0, oerr_exp));
      else if (c <= 4)  sb.push_back(mk(1, 6 - c, 0, 0, oerr_exp));
      else if (c <= 9)  sb.push_back(mk(1, 10 - c, 0, 0, oerr_exp));
      else if (c == 10) sb.push_back(mk(0, 0, 1, 0, oerr_exp));
      else              sb.push_back(mk(0, 0, 0, 0, oerr_exp));
      @(negedge clk);
      o = sample(); e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL overlap c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  // DIV aborted by rst while remain=3: no done pulse, overlap_err cleared.
  task automatic test_reset_mid();
    obs_t e, o;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      rst = (c == 8);
      drive(c == 0, MDU_DIV, 1'b0, 1'b1, MDU_MFHI);
      if (c >= 9) oerr_exp = 1'b0;
      if (c == 0)      sb.push_back(mk(0, 0, 0, 1, oerr_exp));
      else if (c <= 8) sb.push_back(mk(1, 11 - c, 0, 1, oerr_exp));
      else             sb.push_back(mk(0, 0, 0, 0, oerr_exp));
      @(negedge clk);
      o = sample(); e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rst_mid c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, MDU_NOP, 1'b0, 1'b0, MDU_NOP);
    @(posedge clk);
    test_reset();
    test_mult();
    test_divu_nonmdu();
    test_flush();
    test_back_to_back();
    test_overlap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_stall_ctrl.md
Name: mdu_stall_ctrl

Overview:
- Decode-stage companion to the multiply/divide unit.
- Tracks how many cycles a multiply or divide takes from the moment the E-stage issues it. Stalls the D-stage whenever the instruction in D touches HI/LO while the unit is busy or starting.
- Emits a one-cycle completion pulse and an occupancy count for the pipeline hazard logic and debug.

Parameters:
- MULT_CYCLES, 5, busy cycles after issue for MULT/MULTU/MADDU.
- DIV_CYCLES, 10, busy cycles after issue for DIV/DIVU.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- e_valid  in  1  E-stage holds a live instruction.
- e_mdu_op  in  4  MDUOp of the E-stage instruction.
- e_flush  in  1  E-stage instruction cancelled this cycle.
- d_valid  in  1  D-stage holds a live instruction.
- d_mdu_op  in  4  MDUOp of the D-stage instruction; NOP code when it is not an MDU op.
- stall_d  out  1  freeze PC/F/D and insert a bubble into E.
- busy  out  1  unit occupied by a multiply or divide.
- remain  out  CNT_W  busy cycles left, including the current one.
- done  out  1  one-cycle pulse in the cycle after the last busy cycle.
- overlap_err  out  1  sticky; set when a start arrives while busy.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, remain=0, busy=0, done=0, overlap_err=0.
  - Reset overrides every other input, including a start in the same cycle.
  - A reset mid-operation abandons the count immediately.
- start = e_valid & ~e_flush & e_mdu_op in {MULT, MULTU, DIV, DIVU, MADDU}.
- Load value = DIV_CYCLES for DIV/DIVU, MULT_CYCLES otherwise.
- State IDLE:
  - On start: at next edge, remain <= load, busy <= 1, go to BUSY.
  - Otherwise hold.
- State BUSY:
  - Each edge: remain <= remain-1.
  - When remain==1 at the edge: remain <= 0, busy <= 0, done <= 1 for exactly one cycle, go to IDLE.
  - Start in BUSY (illegal, since stall_d should prevent it): reload the counter with the new load value, stay in BUSY, set overlap_err. overlap_err clears only on rst.
- Timing: busy is high for exactly N consecutive cycles, beginning the cycle after the start cycle. done is high in cycle N+1.
- Counter never wraps. remain==0 exactly when IDLE.
- d_uses = d_valid & d_mdu_op in {MULT, MULTU, DIV, DIVU, MADDU, MTHI, MTLO, MFHI, MFLO}.
- stall_d = d_uses & (start | busy). This output is combinational from current inputs and state.
  - The start term covers the cycle in which the op is still in E, before busy rises.
- e_flush suppresses start only; it does not cancel an operation already counting.
- done and a new start in the same cycle (IDLE): start is accepted; done still pulses.
- A D-stage non-MDU instruction never stalls, whatever the state.
- MDUOp encodings come from the shared constants; undefined codes are treated as non-MDU.

Decomposition:
- MDUOp macros (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADDU, MFHI, MFLO, NOP) stay in the shared constants file; add no local encodings.
- Add the IDLE/BUSY state codes to the same file.
- Optional sub-module mdu_op_class: combinational decode of MDUOp into is_start/is_div/uses_hilo. It is instantiated twice, for E and D.
- The rest is a single always block plus the stall_d expression.

Test Plan:
- MULT issued (e_valid=1, e_mdu_op=MULT) at cycle 0, D holds MFLO:
  - stall_d=1 in cycles 0..5.
  - busy=1 in cycles 1..5; remain 5,4,3,2,1.
  - done=1 in cycle 6, with stall_d=0 that cycle.
- DIVU issued, D holds ADD (non-MDU):
  - busy=1 for 10 cycles; stall_d stays 0 throughout.
  - Then D holds MTHI: stall_d=1 until busy falls.
- DIV with e_flush=1 in the issue cycle:
  - busy, remain and done stay 0; a D-stage MFHI gets stall_d=0.
- rst=1 asserted at remain=3 during DIV:
  - Next cycle busy=0, remain=0, done=0; no done pulse ever follows.
- Forced MULTU start while remain=2 (stall_d ignored by the bench):
  - remain reloads to 5; overlap_err=1 and stays set until rst.
- Back-to-back: MULT completes, and a new DIV start arrives in the done cycle:
  - done=1 that cycle; busy=1 for the next 10 cycles.
